// File: rtl/branch_resolve_unit.sv
// Branch resolution stage with branch history table and misprediction counter.
//
// Evaluates the six RISC-V conditional branch conditions, compares the outcome
// against the fetch-time prediction and registers the result (direction,
// mispredict flag, correct next PC) one cycle after the accepting edge. Also
// owns the 2-bit saturating-counter BHT read combinationally by fetch, and a
// saturating misprediction counter.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   lookup_pc         fetch PC to predict
//   lookup_taken      prediction (MSB of indexed BHT counter, pre-update value)
//   res_valid         resolve request this cycle
//   is_branch         request is a conditional branch
//   branch_op         condition to evaluate
//   src_a, src_b      operands
//   res_pc            PC of resolving instruction
//   res_target        taken target
//   pred_taken        prediction made at fetch
//   flush             kill the request presented this cycle
//   out_valid         registered result valid
//   branch_taken      registered resolved direction
//   mispredict        registered direction != prediction
//   redirect_pc       registered correct next PC (holds when no result)
//   mispredict_count  saturating count of mispredictions

package branches_pkg;
  // Encodings follow the branch funct3 field; 3'b010 and 3'b011 are undefined.
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_op_e;
endpackage

module branch_resolve_unit
  import branches_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  CTR_INIT    = 2'b01,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     lookup_pc,
  output logic                 lookup_taken,
  input  logic                 res_valid,
  input  logic                 is_branch,
  input  branch_op_e           branch_op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic [WIDTH-1:0]     res_pc,
  input  logic [WIDTH-1:0]     res_target,
  input  logic                 pred_taken,
  input  logic                 flush,
  output logic                 out_valid,
  output logic                 branch_taken,
  output logic                 mispredict,
  output logic [WIDTH-1:0]     redirect_pc,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned IDX_BITS = $clog2(BHT_ENTRIES);

  logic                 accept;
  logic                 resolve;
  logic                 cond;
  logic                 mis_event;
  logic [WIDTH-1:0]     seq_pc;
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [IDX_BITS-1:0]  res_idx;
  logic [1:0]           ctr_cur;
  logic [1:0]           ctr_next;

  logic [1:0]           bht_q [BHT_ENTRIES];
  logic                 out_valid_q, out_valid_d;
  logic                 branch_taken_q, branch_taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [WIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Low PC bits and bits above the index are deliberately ignored (aliasing).
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[WIDTH-1:IDX_BITS+2], lookup_pc[1:0]};

  assign accept     = res_valid && !flush;
  assign resolve    = accept && is_branch;
  assign mis_event  = resolve && (cond != pred_taken);
  assign seq_pc     = res_pc + WIDTH'(4);
  assign lookup_idx = lookup_pc[IDX_BITS+1:2];
  assign res_idx    = res_pc[IDX_BITS+1:2];

  // No bypass: fetch sees the counter as it stands before this cycle's update.
  assign lookup_taken = bht_q[lookup_idx][1];

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      BR_EQ:   cond = (src_a == src_b);
      BR_NE:   cond = (src_a != src_b);
      BR_LT:   cond = ($signed(src_a) <  $signed(src_b));
      BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
      BR_LTU:  cond = (src_a <  src_b);
      BR_GEU:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    ctr_cur  = bht_q[res_idx];
    ctr_next = ctr_cur;
    if (cond) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    out_valid_d    = accept;
    branch_taken_d = 1'b0;
    mispredict_d   = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    if (accept) begin
      redirect_pc_d = seq_pc;
      if (is_branch) begin
        branch_taken_d = cond;
        mispredict_d   = (cond != pred_taken);
        if (cond) redirect_pc_d = res_target;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (mis_event && (count_q != {CNT_WIDTH{1'b1}})) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      branch_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      count_q        <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      branch_taken_q <= branch_taken_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
    end else if (resolve) begin
      bht_q[res_idx] <= ctr_next;
    end
  end

  assign out_valid        = out_valid_q;
  assign branch_taken     = branch_taken_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = count_q;

endmodule
